// File: rtl/round_key_sched_ctrl_pkg.sv
// Shared definitions for the round key schedule controller: FSM states,
// per-state expansion mux select vectors and parameter defaults.
package round_key_sched_ctrl_pkg;

  localparam int ROUNDS_DEF    = 10;
  localparam int KEY_BYTES_DEF = 16;

  localparam logic [3:0] CNT_LAST = 4'd15;
  localparam logic [3:0] TWO_END  = 4'd2;
  localparam logic [3:0] NORM_END = 4'd11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ONE,
    ST_TWO,
    ST_THREE,
    ST_NORM,
    ST_SHIFT,
    ST_DONE,
    ST_CLEAR
  } state_t;

  typedef struct packed {
    logic       sel_input;
    logic       sel_sbox;
    logic       sel_last;
    logic       sel_bit;
    logic [7:0] rcon_en;
  } sel_t;

  localparam sel_t SEL_LOAD  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
  localparam sel_t SEL_ONE   = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hFF};
  localparam sel_t SEL_TWO   = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
  localparam sel_t SEL_THREE = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
  localparam sel_t SEL_NORM  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
  localparam sel_t SEL_SHIFT = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};

  // Idle, done and clearing all present the load vector to the datapath.
  function automatic sel_t sel_of(input state_t s);
    case (s)
      ST_ONE:   return SEL_ONE;
      ST_TWO:   return SEL_TWO;
      ST_THREE: return SEL_THREE;
      ST_NORM:  return SEL_NORM;
      ST_SHIFT: return SEL_SHIFT;
      default:  return SEL_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/round_key_sched_ctrl_rk_store.sv
// Round key register file: ROUNDS+1 entries, one write port and one
// registered read port whose output holds until the next enabled read.
module rk_store
  import round_key_sched_ctrl_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int KEY_W  = 8 * KEY_BYTES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_idx,
  input  logic [KEY_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_data
);

  logic [KEY_W-1:0] mem [ROUNDS+1];

  // Key material is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/round_key_sched_ctrl.sv
// Round key schedule controller for a byte-serial key expansion datapath.
// Optional storage zeroization is enabled by defining ROUND_KEY_SCHED_ZEROIZE_EN.
module round_key_sched_ctrl
  import round_key_sched_ctrl_pkg::*;
#(
  parameter int ROUNDS    = ROUNDS_DEF,
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_load,
  input  logic [8*KEY_BYTES-1:0] key_in,
  output logic                   key_ready,
  output logic                   keys_valid,
  output logic [7:0]             ke_key_byte,
  output logic                   ke_sel_input,
  output logic                   ke_sel_sbox,
  output logic                   ke_sel_last,
  output logic                   ke_sel_bit,
  output logic [7:0]             ke_rcon_en,
  output logic [3:0]             ke_round,
  input  logic [7:0]             ke_round_byte,
  input  logic                   rk_req,
  input  logic [3:0]             rk_idx,
  output logic                   rk_valid,
  output logic [8*KEY_BYTES-1:0] rk_key,
  output logic                   rk_err
);

  localparam int         KEY_W      = 8 * KEY_BYTES;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  state_t             state_q, state_d;
  logic [3:0]         cnt;
  logic [3:0]         round;
  logic [KEY_W-1:0]   shreg;
  logic [KEY_W-9:0]   rbuf;
  logic               accept;
  logic               window;
  logic               last_round;
  logic               rd_ok;
  logic               wr_en;
  logic [3:0]         wr_idx;
  logic [KEY_W-1:0]   wr_data;
  sel_t               sel;
`ifdef ROUND_KEY_SCHED_ZEROIZE_EN
  logic               zload;
`endif

  assign window     = (state_q == ST_ONE) || (state_q == ST_TWO) || (state_q == ST_THREE) ||
                      (state_q == ST_NORM) || (state_q == ST_SHIFT);
  assign last_round = (round == LAST_ROUND);
  assign key_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign rd_ok      = rk_req && keys_valid && !accept && (rk_idx <= LAST_ROUND);

  assign sel          = sel_of(state_q);
  assign ke_sel_input = sel.sel_input;
  assign ke_sel_sbox  = sel.sel_sbox;
  assign ke_sel_last  = sel.sel_last;
  assign ke_sel_bit   = sel.sel_bit;
  assign ke_rcon_en   = sel.rcon_en;
  assign ke_round     = round;
  assign ke_key_byte  = shreg[KEY_W-1 -: 8];

  // cnt runs 0..15 through LOAD and through every round window, so state
  // boundaries inside the window are fixed cnt values.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (key_load) begin
          accept = 1'b1;
`ifdef ROUND_KEY_SCHED_ZEROIZE_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef ROUND_KEY_SCHED_ZEROIZE_EN
      ST_CLEAR: if (cnt == LAST_ROUND) state_d = zload ? ST_LOAD : ST_IDLE;
`endif
      ST_LOAD:  if (cnt == CNT_LAST) state_d = ST_ONE;
      ST_ONE:   state_d = ST_TWO;
      ST_TWO:   if (cnt == TWO_END) state_d = ST_THREE;
      ST_THREE: state_d = ST_NORM;
      ST_NORM:  if (cnt == NORM_END) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_LAST) state_d = last_round ? ST_DONE : ST_ONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef ROUND_KEY_SCHED_ZEROIZE_EN
      state_q <= ST_CLEAR;
      zload   <= 1'b0;
`else
      state_q <= ST_IDLE;
`endif
      cnt        <= '0;
      round      <= '0;
      shreg      <= '0;
      rbuf       <= '0;
      keys_valid <= 1'b0;
      rk_valid   <= 1'b0;
      rk_err     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rk_valid <= rd_ok;
      rk_err   <= rk_req && !rd_ok;
      if (accept) begin
        shreg      <= key_in;
        cnt        <= '0;
        round      <= '0;
        keys_valid <= 1'b0;
`ifdef ROUND_KEY_SCHED_ZEROIZE_EN
        zload      <= 1'b1;
`endif
      end else if (state_q == ST_CLEAR) begin
        cnt <= (cnt == LAST_ROUND) ? '0 : cnt + 1'b1;
      end else if (state_q == ST_LOAD) begin
        shreg <= {shreg[KEY_W-9:0], 8'h00};
        cnt   <= cnt + 1'b1;
        if (cnt == CNT_LAST) round <= 4'd1;
      end else if (window) begin
        // Returned bytes enter at the bottom; after 15 shifts byte 0 sits on top.
        rbuf <= {rbuf[KEY_W-17:0], ke_round_byte};
        cnt  <= cnt + 1'b1;
        if (state_q == ST_SHIFT && cnt == CNT_LAST) begin
          if (last_round) keys_valid <= 1'b1;
          else            round      <= round + 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
`ifdef ROUND_KEY_SCHED_ZEROIZE_EN
    // Clear from the top entry down; the final slot receives the held key.
    if (state_q == ST_CLEAR) begin
      wr_en  = 1'b1;
      wr_idx = LAST_ROUND - cnt;
      if (cnt == LAST_ROUND && zload) wr_data = shreg;
    end
`else
    if (accept) begin
      wr_en   = 1'b1;
      wr_data = key_in;
    end
`endif
    if (window && cnt == CNT_LAST) begin
      wr_en   = 1'b1;
      wr_idx  = round;
      wr_data = {rbuf, ke_round_byte};
    end
  end

  rk_store #(
    .ROUNDS (ROUNDS),
    .KEY_W  (KEY_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_en   (rd_ok),
    .rd_idx  (rk_idx),
    .rd_data (rk_key)
  );

endmodule

// File: doc/round_key_sched_ctrl.md
ROUND_KEY_SCHED_CTRL -- requirements
Module: round_key_sched_ctrl

Interface
REQ-001 Parameter ROUNDS, default 10, number of expanded round keys after round 0.
REQ-002 Parameter KEY_BYTES, default 16, bytes per round key.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 key_load  in  1  start expansion of key_in; accepted only when key_ready=1.
REQ-006 key_in  in  128  cipher key, byte 0 = bits [127:120].
REQ-007 key_ready  out  1  controller idle or done, can accept key_load.
REQ-008 keys_valid  out  1  all ROUNDS+1 round keys stored for current key.
REQ-009 ke_key_byte  out  8  serial key byte to byte-serial expansion datapath.
REQ-010 ke_sel_input, ke_sel_sbox, ke_sel_last, ke_sel_bit  out  1 each  expansion mux selects.
REQ-011 ke_rcon_en  out  8  rcon update enable mask (8'hFF or 8'h00).
REQ-012 ke_round  out  4  current expansion round, 0..ROUNDS.
REQ-013 ke_round_byte  in  8  round-key byte returned by expansion datapath.
REQ-014 rk_req  in  1  round-key read request.
REQ-015 rk_idx  in  4  requested round index.
REQ-016 rk_valid  out  1  one-cycle pulse, rk_key valid.
REQ-017 rk_key  out  128  requested round key.
REQ-018 rk_err  out  1  one-cycle pulse: rk_idx>ROUNDS or keys_valid=0.

Function
REQ-019 FSM states IDLE, LOAD, ONE, TWO, THREE, NORM, SHIFT, DONE.
REQ-020 IDLE/DONE + key_load -> LOAD; key_in latched into 128-bit shift register and stored as round key 0; keys_valid cleared same edge.
REQ-021 LOAD lasts 16 cycles, one byte of key_in per cycle on ke_key_byte, MSB byte first.
REQ-022 Round window = ONE(1) + TWO(2) + THREE(1) + NORM(8) + SHIFT(4) = 16 cycles; SHIFT last cycle -> ONE, or -> DONE after round ROUNDS.
REQ-023 Selects (input,sbox,last,bit,rcon): LOAD 0,1,0,0,00; ONE 1,1,0,1,FF; TWO 1,1,0,1,00; THREE 1,0,0,1,00; NORM 1,0,1,1,00; SHIFT 1,0,1,0,00; IDLE/DONE same as LOAD.
REQ-024 ke_round increments on each ONE entry, 1..ROUNDS; 0 in IDLE/LOAD; holds ROUNDS in DONE.
REQ-025 Byte k (0..15) of round r captured from ke_round_byte on window cycle k (cycle 0 = ONE), into bits [127-8k -: 8] of entry r.
REQ-026 Entry r written to storage on window cycle 15; after round ROUNDS write, keys_valid=1 next cycle, state DONE.
REQ-027 Total latency key_load accept -> keys_valid = 16 + 16*ROUNDS + 1 cycles (177 for default).
REQ-028 key_ready=1 in IDLE and DONE only; key_load ignored otherwise.
REQ-029 Read: rk_req with keys_valid=1 and rk_idx<=ROUNDS -> rk_valid=1, rk_key=entry, next cycle; else rk_err=1 next cycle, rk_key unchanged.
REQ-030 Reads allowed back-to-back every cycle; key_load and rk_req same cycle in DONE: load wins, read returns rk_err.
REQ-031 rk_key holds last valid value between reads.

Reset
REQ-032 rst (any state, mid-expansion included) -> IDLE, key_ready=1, keys_valid=0, rk_valid=0, rk_err=0, ke_round=0, rk_key=0, selects as LOAD.
REQ-033 Storage contents not reset unless REQ-035 applies.

Configuration
REQ-034 Macro ROUND_KEY_SCHED_ZEROIZE_EN absent: storage retains old keys across rst and new load.
REQ-035 ROUND_KEY_SCHED_ZEROIZE_EN defined: rst and key_load accept clear all entries to 0 over ROUNDS+1 cycles before LOAD proceeds; key_ready=0 during clear; latency per REQ-027 grows by ROUNDS+1.

Structure
REQ-036 Shared package holds FSM state encoding, select-vector constants per state, ROUNDS/KEY_BYTES defaults.
REQ-037 One sub-module rk_store: (ROUNDS+1)x128 register file, one write port, one registered read port.

Verification
REQ-038 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, load -> keys_valid after 177 cycles; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-039 Read rk_idx=0 after DONE -> rk_key = key_in; rk_idx=11 -> rk_err pulse, rk_valid=0.
REQ-040 rst asserted at cycle 60 of expansion -> IDLE next cycle, keys_valid=0; reload completes correctly in 177 cycles.
REQ-041 Per-state select vectors checked every cycle against REQ-023 table; rcon_en=FF exactly 10 cycles per key.
REQ-042 key_load while busy ignored; key_load+rk_req same cycle in DONE -> rk_err, new expansion starts.
REQ-043 With ROUND_KEY_SCHED_ZEROIZE_EN: after load accept all entries read 0 post-rst; latency 188 cycles.
